// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use bubbles, branch redirect with fetch drain,
// data-memory wait freezes and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [4:0]       addr1,
    input  logic [4:0]       addr2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_Rmem,
    input  logic             ex_Wreg,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush,
    output logic             pc_redirect,
    output logic             hold_all,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;
    localparam logic [3:0] FC      = 4'(FLUSH_CYCLES);

    logic [0:0]       state_q, state_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic stall_inc, flush_inc;
    logic c_stall_pc, c_stall_ifid, c_flush_ifid;
    logic c_flush, c_redirect, c_hold;

    // Producer in EX is a load whose rd matches a source decode actually reads.
    assign lu = ex_Rmem & ex_Wreg & (ex_rd != 5'd0)
              & ((use_rs1 & (addr1 == ex_rd))
              |  (use_rs2 & (addr2 == ex_rd)));

    // Control decode with priority mem wait > drain > branch > load-use.
    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        c_stall_pc   = 1'b0;
        c_stall_ifid = 1'b0;
        c_flush_ifid = 1'b0;
        c_flush      = 1'b0;
        c_redirect   = 1'b0;
        c_hold       = 1'b0;
        if (!mem_ready) begin
            c_hold    = 1'b1;
            stall_inc = 1'b1;
        end else if (state_q == S_DRAIN) begin
            c_flush_ifid = 1'b1;
            stall_inc    = 1'b1;
            dcnt_d       = dcnt_q - 4'd1;
            if (dcnt_q <= 4'd1) begin
                state_d = S_RUN;
                dcnt_d  = 4'd0;
            end
        end else if (branch_taken) begin
            c_redirect   = 1'b1;
            c_flush_ifid = 1'b1;
            c_flush      = 1'b1;
            flush_inc    = 1'b1;
            if (FC != 4'd0) begin
                state_d = S_DRAIN;
                dcnt_d  = FC;
            end
        end else if (lu) begin
            c_stall_pc   = 1'b1;
            c_stall_ifid = 1'b1;
            c_flush      = 1'b1;
            stall_inc    = 1'b1;
        end
    end

    // Saturating counters; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && !(&stall_cnt_q))
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush_inc && !(&flush_cnt_q))
                flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State, drain count and counter registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_RUN;
            dcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset forces every control low without waiting for a clock.
    assign stall_pc    = nReset & c_stall_pc;
    assign stall_ifid  = nReset & c_stall_ifid;
    assign flush_ifid  = nReset & c_flush_ifid;
    assign flush       = nReset & c_flush;
    assign pc_redirect = nReset & c_redirect;
    assign hold_all    = nReset & c_hold;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int FCY  = 2;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic [4:0]    addr1 = '0, addr2 = '0, ex_rd = '0;
    logic          use_rs1 = 0, use_rs2 = 0;
    logic          ex_Rmem = 0, ex_Wreg = 0;
    logic          branch_taken = 0, mem_ready = 1, cnt_clr = 0;
    logic          stall_pc, stall_ifid, flush_ifid;
    logic          flush, pc_redirect, hold_all;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.FLUSH_CYCLES(FCY), .CNT_W(CW)) dut (
        .Clock(Clock), .nReset(nReset),
        .addr1(addr1), .addr2(addr2),
        .use_rs1(use_rs1), .use_rs2(use_rs2),
        .ex_rd(ex_rd), .ex_Rmem(ex_Rmem), .ex_Wreg(ex_Wreg),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .cnt_clr(cnt_clr),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .flush_ifid(flush_ifid), .flush(flush),
        .pc_redirect(pc_redirect), .hold_all(hold_all),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [5:0]    ctrl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: remaining drain cycles and counter values.
    int   m_drain = 0;
    int   m_sc = 0;
    int   m_fc = 0;

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    // Expected outputs for the current inputs, then advance the model.
    task automatic model_push();
        exp_t e;
        logic sp, si, fi, fl, rd, ho, lu;
        int   nsc, nfc;
        sp = 0; si = 0; fi = 0; fl = 0; rd = 0; ho = 0;
        e.sc = m_sc[CW-1:0];
        e.fc = m_fc[CW-1:0];
        nsc = m_sc;
        nfc = m_fc;
        lu = ex_Rmem && ex_Wreg && ex_rd != 0 &&
             ((use_rs1 && addr1 == ex_rd) || (use_rs2 && addr2 == ex_rd));
        if (!nReset) begin
            m_drain = 0; m_sc = 0; m_fc = 0;
            e.sc = 0; e.fc = 0;
        end else begin
            if (!mem_ready) begin
                ho = 1; nsc = sat(m_sc);
            end else if (m_drain > 0) begin
                fi = 1; nsc = sat(m_sc); m_drain--;
            end else if (branch_taken) begin
                rd = 1; fi = 1; fl = 1;
                nfc = sat(m_fc); m_drain = FCY;
            end else if (lu) begin
                sp = 1; si = 1; fl = 1; nsc = sat(m_sc);
            end
            if (cnt_clr) begin
                nsc = 0; nfc = 0;
            end
            m_sc = nsc;
            m_fc = nfc;
        end
        e.ctrl = {sp, si, fi, fl, rd, ho};
        q.push_back(e);
    endtask

    task automatic drive(input logic mr, bt, rm, wr,
                         input logic [4:0] rd, a1, a2,
                         input logic u1, u2, clr);
        @(posedge Clock);
        #1;
        mem_ready = mr; branch_taken = bt;
        ex_Rmem = rm; ex_Wreg = wr; ex_rd = rd;
        addr1 = a1; addr2 = a2; use_rs1 = u1; use_rs2 = u2;
        cnt_clr = clr;
        model_push();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset between edges, hold across one edge, release late.
    task automatic do_reset();
        @(posedge Clock);
        #1;
        nReset = 0;
        branch_taken = 1; mem_ready = 1;
        model_push();
        @(posedge Clock);
        #1;
        mem_ready = 0;
        model_push();
        #6;
        nReset = 1;
        branch_taken = 0; mem_ready = 1;
    endtask

    // Monitor: compare DUT against the oldest expectation each negedge.
    always @(negedge Clock) begin
        exp_t e;
        logic [5:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {stall_pc, stall_ifid, flush_ifid,
                   flush, pc_redirect, hold_all};
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl t=%0t got %b want %b", $time, act, e.ctrl);
            end
            checks++;
            if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                errors++;
                $display("FAIL cnt t=%0t got s=%0d f=%0d want s=%0d f=%0d",
                         $time, stall_cnt, flush_cnt, e.sc, e.fc);
            end
        end
    end

    initial begin
        do_reset();
        // load-use on rs1, then the same with rd=x0
        drive(1, 0, 1, 1, 5, 5, 0, 1, 0, 0);
        idle(1);
        drive(1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        // load-use on rs2 and non-read source
        drive(1, 0, 1, 1, 7, 0, 7, 0, 1, 0);
        drive(1, 0, 1, 1, 7, 7, 0, 0, 0, 0);
        // branch pulse and full drain
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // wait inside drain cycle 1
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // branch together with load-use
        drive(1, 1, 1, 1, 3, 3, 3, 1, 1, 0);
        idle(3);
        // wait together with branch, then re-presented
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // saturation
        for (int i = 0; i < 20; i++)
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // reset in the middle of a drain
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle(2);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 7) == 0),
                  1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom),
                  ($urandom_range(0, 40) == 0));
            if ($urandom_range(0, 150) == 0)
                do_reset();
        end
        // drain scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++)
            @(posedge Clock);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain left=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the `flush` input of the ID/EX register and the hold/flush controls of the fetch side. It sees the decoding instruction's source addresses, the ID/EX register's outputs and the execute/memory status. From these it sequences load-use bubbles, taken-branch flushes with a multi-cycle fetch drain, and data-memory wait freezes. It also keeps saturating stall and flush performance counters.

## Interface

Parameters:
- FLUSH_CYCLES, 1, extra cycles IF/ID is flushed after a redirect to cover instruction-memory latency (0..15)
- CNT_W, 16, width of the performance counters

Ports:
- Clock  in  1  system clock, rising edge
- nReset  in  1  asynchronous active-low reset
- addr1  in  5  rs1 address of the instruction in decode
- addr2  in  5  rs2 address of the instruction in decode
- use_rs1  in  1  decode instruction reads rs1
- use_rs2  in  1  decode instruction reads rs2
- ex_rd  in  5  rd_out of the ID/EX register
- ex_Rmem  in  1  Rmem_out of the ID/EX register
- ex_Wreg  in  1  Wreg_out of the ID/EX register
- branch_taken  in  1  execute resolved a taken branch or jump this cycle
- mem_ready  in  1  data memory can complete this cycle (0 = wait)
- cnt_clr  in  1  synchronous clear of both counters
- stall_pc  out  1  PC holds its value
- stall_ifid  out  1  IF/ID register holds its value
- flush_ifid  out  1  IF/ID register loads a bubble
- flush  out  1  to ID/EX `flush`: ID/EX loads a bubble
- pc_redirect  out  1  PC loads the execute branch target
- hold_all  out  1  freeze every pipeline register and the PC
- stall_cnt  out  CNT_W  cycles lost to stalls, saturating
- flush_cnt  out  CNT_W  redirects taken, saturating

## Operation

- Load-use hazard: lu = ex_Rmem & ex_Wreg & (ex_rd != 0) & ((use_rs1 & addr1 == ex_rd) | (use_rs2 & addr2 == ex_rd)).
- State machine: RUN, DRAIN. A 4-bit drain counter `dcnt` is used in DRAIN.
- Priority in every cycle: mem wait > branch > load-use.
- Memory wait (mem_ready = 0, any state):
  - hold_all = 1; all other control outputs are 0.
  - State and dcnt are frozen.
  - stall_cnt increments.
- RUN, mem_ready = 1:
  - On branch_taken: pc_redirect = flush_ifid = flush = 1, and flush_cnt increments. If FLUSH_CYCLES > 0, go to DRAIN with dcnt = FLUSH_CYCLES; otherwise stay in RUN. lu is ignored in that cycle.
  - Otherwise, on lu: stall_pc = stall_ifid = flush = 1, and stall_cnt increments. Stay in RUN. The bubble clears ex_Rmem, so lu drops on the next cycle.
  - Otherwise, all control outputs are 0.
- DRAIN, mem_ready = 1:
  - flush_ifid = 1; all other control outputs are 0.
  - branch_taken and lu are ignored; EX holds a bubble.
  - dcnt decrements. When dcnt == 1, return to RUN.
  - stall_cnt increments each DRAIN cycle.
- Counters:
  - Saturate at 2^CNT_W − 1.
  - cnt_clr has priority over increment: counters go to 0 on the next edge.
- Control outputs are combinational from state and inputs, and are forced to 0 while nReset is low.

## Timing

- Reset (asynchronous, nReset low):
  - State = RUN, dcnt = 0, stall_cnt = 0, flush_cnt = 0.
  - All control outputs are 0 immediately, with no clock needed.
- Deassertion: normal operation starts at the first rising edge after nReset goes high.
- Load-use: flush is asserted in the same cycle lu is true, and ID/EX captures the bubble at that edge. The dependent instruction issues one cycle later, giving exactly 1 bubble.
- Branch: redirect and both flushes are in the same cycle as branch_taken. Total IF/ID flush cycles = 1 + FLUSH_CYCLES.
- Memory wait of N cycles inserts exactly N frozen cycles. A DRAIN interrupted by a wait resumes with the same dcnt.
- Simultaneous branch_taken and lu: branch wins, and stall_cnt does not increment.
- Simultaneous !mem_ready and branch_taken: hold_all only. The branch must be re-presented when mem_ready rises, because EX is held.
- Reset asserted mid-DRAIN: return to RUN immediately; no residual flush.

## Test plan

- Load-use: ex_Rmem = ex_Wreg = 1, ex_rd = 5, addr1 = 5, use_rs1 = 1 → stall_pc = stall_ifid = flush = 1 for 1 cycle; stall_cnt 0→1. Same with ex_rd = 0 → no stall.
- Branch with FLUSH_CYCLES = 2: branch_taken pulsed one cycle → cycle 0: pc_redirect = flush = flush_ifid = 1; cycles 1–2: flush_ifid only; cycle 3: RUN with all outputs 0; flush_cnt = 1.
- Wait inside DRAIN: mem_ready = 0 for 3 cycles during DRAIN cycle 1 → hold_all = 1 for 3 cycles, then the remaining drain cycle completes; stall_cnt += 3 + drain cycles.
- Priority: branch_taken and lu together → branch response only. !mem_ready with branch_taken → hold_all only; pc_redirect = 0.
- Counter saturation and clear: CNT_W = 4, force 20 stall cycles → stall_cnt = 15. cnt_clr together with a stall → stall_cnt = 0 next cycle.
- Reset mid-DRAIN: nReset low between edges → all outputs 0 asynchronously. After release, state RUN and counters 0.
